// File: rtl/total_adder.sv
// Registered ripple-carry adder: {carry_out,sum} <= a + b + cin, built from a chain of full-adder cells.
// Optional build macro TOTAL_ADDER_INREG_EN inserts an input register stage (latency 2 instead of 1).
module total_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

`ifdef TOTAL_ADDER_INREG_EN
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cin <= 1'b0;
    end else begin
      r_a   <= a;
      r_b   <= b;
      r_cin <= cin;
    end
  end

  assign w_a   = r_a;
  assign w_b   = r_b;
  assign w_cin = r_cin;
`else
  assign w_a   = a;
  assign w_b   = b;
  assign w_cin = cin;
`endif

  assign w_c[0] = w_cin;

  // One full-adder cell per bit; carry ripples from LSB to MSB.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign w_s[gi]   = w_a[gi] ^ w_b[gi] ^ w_c[gi];
      assign w_c[gi+1] = (w_a[gi] & w_b[gi]) | (w_c[gi] & (w_a[gi] ^ w_b[gi]));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_sum   <= w_s;
      r_carry <= w_c[WIDTH];
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_carry;

endmodule

// File: tb/tb_total_adder.sv
// Self-checking bench for total_adder: directed corner cases, async reset behaviour, then random traffic.
// Expected results come from plain integer addition; latency follows TOTAL_ADDER_INREG_EN.
module tb_total_adder;
  localparam int W = 4;
`ifdef TOTAL_ADDER_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic         cin;
  logic [W-1:0] sum;
  logic         carry_out;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W:0] exp_q[$];

  total_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
    .sum(sum), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] ref_add(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    int total;
    total = int'(xa) + int'(xb) + int'(xc);
    return total[W:0];
  endfunction

  task automatic check(input string tag, input logic [W:0] expv);
    logic [W:0] obs;
    obs = {carry_out, sum};
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed {carry_out,sum}=%0d (0x%h) expected %0d (0x%h)", tag, obs, obs, expv, expv);
    end
    $display("check %-12s obs=%0d exp=%0d", tag, obs, expv);
  endtask

  // Drive one vector at the falling edge; first check the result due from LAT vectors ago.
  task automatic step(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    @(negedge clk);
    if (exp_q.size() == LAT) check(tag, exp_q.pop_front());
    a = ta; b = tb_v; cin = tc;
    exp_q.push_back(ref_add(ta, tb_v, tc));
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check(tag, exp_q.pop_front());
    end
  endtask

  initial begin
    logic [W:0] held;
    rst_n = 1'b0; a = 4'hF; b = 4'hF; cin = 1'b1;

    // Reset holds outputs at zero across edges and between edges.
    #1 check("rst_init", '0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2 check("rst_pos", '0);
      @(negedge clk); check("rst_neg", '0);
    end
    rst_n = 1'b1;
    exp_q.delete();

    step("zero",   4'd0,  4'd0,  1'b0);
    step("5+3",    4'd5,  4'd3,  1'b0);
    step("max",    4'd15, 4'd15, 1'b1);
    step("wrap1",  4'd12, 4'd10, 1'b0);
    step("wrap2",  4'd14, 4'd3,  1'b1);
    drain("dir_drain");

    // Glitches between edges must not reach the outputs.
    @(posedge clk); #1 held = {carry_out, sum};
    a = 4'h9; b = 4'h6; #2 a = 4'hF; b = 4'hF; #1 check("glitch", held);
    @(negedge clk); a = 4'd14; b = 4'd3; cin = 1'b1;
    repeat (LAT) @(posedge clk);
    #1 check("post_glitch", ref_add(4'd14, 4'd3, 1'b1));

    // Mid-cycle reset: outputs clear at once, result reappears LAT edges after release.
    @(negedge clk); a = 4'd5; b = 4'd3; cin = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1 check("mid_rst", '0);
    @(negedge clk); check("mid_rst_neg", '0);
    rst_n = 1'b1;
    repeat (LAT) @(posedge clk);
    #1 check("rel_5+3", ref_add(4'd5, 4'd3, 1'b0));

    exp_q.delete();
    for (int i = 0; i < 200; i++) begin
      step($sformatf("rnd%0d", i), W'($urandom), W'($urandom), 1'($urandom));
    end
    drain("rnd_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
